// File: rtl/spi_inst_master.sv
// SPI instruction-frame master: shifts {1'b0, op, data} out MSB first with
// SETUP / HIGH / LOW / HOLD / GAP phases, each DIV clk cycles long.
// Every output is a flop; the combinational process computes each output's
// next value together with the next state.
module spi_inst_master #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [3:0] data,
  output logic       ready,
  output logic       done,
  output logic       ss,
  output logic       sclk,
  output logic       mosi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sr_q, sr_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        ss_q, ss_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  // Next-state and next-output logic; outputs are set on the transition
  // into each state so that they are valid from that state's first cycle.
  // The shift register moves left on LOW->HIGH, so mosi takes sr_q[6]
  // there (the bit that becomes sr[7]) and sr_q[7] on SETUP->HIGH.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 8'd1 : '0;
    bit_d   = bit_q;
    sr_d    = sr_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_SETUP;
          cnt_d   = CNT_LOAD;
          bit_d   = '0;
          sr_d    = {1'b0, op, data};
          ready_d = 1'b0;
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = CNT_LOAD;
          sclk_d  = 1'b1;
          mosi_d  = sr_q[7];
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = CNT_LOAD;
          sclk_d  = 1'b0;
        end
      end
      S_LOW: begin
        if (cnt_q == '0) begin
          bit_d = bit_q + 3'd1;
          cnt_d = CNT_LOAD;
          if (bit_q == 3'd7) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_HIGH;
            sclk_d  = 1'b1;
            sr_d    = {sr_q[6:0], 1'b0};
            mosi_d  = sr_q[6];
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_LOAD;
          ss_d    = 1'b1;
          mosi_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        ss_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b1;
      end
    endcase
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign ss    = ss_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_inst_master.sv
// Directed bench for spi_inst_master: one DIV=4 and one DIV=2 instance,
// a negedge bus monitor with an ALU-slave model, and linear checks.
module tb_spi_inst_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, start0, ready0, done0, ss0, sclk0, mosi0;
  logic [2:0] op0;
  logic [3:0] data0;
  logic       rst1, start1, ready1, done1, ss1, sclk1, mosi1;
  logic [2:0] op1;
  logic [3:0] data1;

  spi_inst_master #(.DIV(4)) dut4 (
    .clk(clk), .rst(rst0), .start(start0), .op(op0), .data(data0),
    .ready(ready0), .done(done0), .ss(ss0), .sclk(sclk0), .mosi(mosi0)
  );

  spi_inst_master #(.DIV(2)) dut2 (
    .clk(clk), .rst(rst1), .start(start1), .op(op1), .data(data1),
    .ready(ready1), .done(done1), .ss(ss1), .sclk(sclk1), .mosi(mosi1)
  );

  logic [1:0] ss_v, sclk_v, mosi_v, done_v, rst_v, rdy_v;
  assign ss_v   = {ss1, ss0};
  assign sclk_v = {sclk1, sclk0};
  assign mosi_v = {mosi1, mosi0};
  assign done_v = {done1, done0};
  assign rst_v  = {rst1, rst0};
  assign rdy_v  = {ready1, ready0};

  // Monitor state, one slot per instance.
  logic       prev_ss[2]   = '{1'b1, 1'b1};
  logic       prev_sclk[2] = '{1'b0, 1'b0};
  logic       prev_rst[2]  = '{1'b1, 1'b1};
  logic [7:0] cap[2]        = '{8'h00, 8'h00};
  logic [7:0] last_frame[2] = '{8'h00, 8'h00};
  logic [7:0] prev_frame[2] = '{8'h00, 8'h00};
  int sslen[2]      = '{0, 0};
  int last_sslen[2] = '{0, 0};
  int falls[2]      = '{0, 0};
  int last_falls[2] = '{0, 0};
  int nframe[2]     = '{0, 0};
  int done_cnt[2]   = '{0, 0};
  int viol[2]       = '{0, 0};
  int hi_run[2]     = '{0, 0};
  int lo_run[2]     = '{0, 0};
  int ph_min[2]     = '{1000, 1000};
  int ph_max[2]     = '{0, 0};
  int ss_hi_run[2]  = '{0, 0};
  int last_gap[2]   = '{0, 0};

  // ALU slave model attached to the DIV=4 instance.
  logic [3:0] alu_a = 4'd0;
  logic [3:0] alu_b = 4'd0;
  logic [3:0] alu_r = 4'd0;

  // Bus monitor: samples on the falling clk edge, captures mosi at sclk
  // falling edges while ss is low, measures phases and flags protocol errors.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_v[i]) begin
        cap[i]    = 8'h00;
        falls[i]  = 0;
        sslen[i]  = 0;
        hi_run[i] = 0;
        lo_run[i] = 0;
        if (done_v[i]) done_cnt[i]++;
      end else begin
        if (!prev_rst[i]) begin
          if (prev_ss[i] && ss_v[i] && (sclk_v[i] != prev_sclk[i])) viol[i]++;
          if ((ss_v[i] != prev_ss[i]) && (prev_sclk[i] || sclk_v[i])) viol[i]++;
        end
        if (prev_ss[i] && !ss_v[i]) begin
          last_gap[i] = ss_hi_run[i];
          sslen[i]    = 0;
          falls[i]    = 0;
          cap[i]      = 8'h00;
          hi_run[i]   = 0;
          lo_run[i]   = 0;
          ph_min[i]   = 1000;
          ph_max[i]   = 0;
        end
        if (!prev_ss[i] && ss_v[i]) begin
          prev_frame[i] = last_frame[i];
          last_frame[i] = cap[i];
          last_sslen[i] = sslen[i];
          last_falls[i] = falls[i];
          nframe[i]++;
          ss_hi_run[i]  = 0;
          if (i == 0) begin
            case (cap[0][6:4])
              3'b100:  alu_a = cap[0][3:0];
              3'b110:  alu_b = cap[0][3:0];
              3'b000:  alu_r = alu_a + alu_b;
              3'b001:  alu_r = alu_a - alu_b;
              default: ;
            endcase
          end
        end
        if (!ss_v[i] && (sclk_v[i] != prev_sclk[i])) begin
          if (prev_sclk[i]) begin
            if (hi_run[i] < ph_min[i]) ph_min[i] = hi_run[i];
            if (hi_run[i] > ph_max[i]) ph_max[i] = hi_run[i];
            hi_run[i] = 0;
            cap[i]    = {cap[i][6:0], mosi_v[i]};
            falls[i]++;
          end else begin
            if (lo_run[i] < ph_min[i]) ph_min[i] = lo_run[i];
            if (lo_run[i] > ph_max[i]) ph_max[i] = lo_run[i];
            lo_run[i] = 0;
          end
        end
        if (ss_v[i]) begin
          ss_hi_run[i]++;
        end else begin
          sslen[i]++;
          if (sclk_v[i]) hi_run[i]++;
          else lo_run[i]++;
        end
        if (done_v[i]) done_cnt[i]++;
      end
      prev_ss[i]   = ss_v[i];
      prev_sclk[i] = sclk_v[i];
      prev_rst[i]  = rst_v[i];
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts clk edges until ready rises on instance i, bounded.
  task automatic wait_ready(input int i, output int n);
    n = 0;
    while (n < 400 && !rdy_v[i]) begin
      tick();
      n++;
    end
    chk("wait_ready_bound", 32'(n < 400), 32'd1);
  endtask

  task automatic send0(input logic [2:0] o, input logic [3:0] d);
    int n;
    op0 = o; data0 = d; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_ready(0, n);
  endtask

  int n, d0, nf0, d1;

  initial begin
    rst0 = 1'b1; start0 = 1'b0; op0 = 3'd0; data0 = 4'd0;
    rst1 = 1'b1; start1 = 1'b0; op1 = 3'd0; data1 = 4'd0;
    tick(); tick();
    chk("rst_ready",  ready0, 1'b1);
    chk("rst_ss",     ss0,    1'b1);
    chk("rst_sclk",   sclk0,  1'b0);
    chk("rst_mosi",   mosi0,  1'b1);
    chk("rst_done",   done0,  1'b0);
    chk("rst2_ready", ready1, 1'b1);
    rst0 = 1'b0; rst1 = 1'b0;
    tick();
    chk("idle_ready", ready0, 1'b1);

    // Load A=5 frame, DIV=4.
    d0 = done_cnt[0]; nf0 = nframe[0];
    op0 = 3'b100; data0 = 4'b0101; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("t1_ready_fall", ready0, 1'b0);
    chk("t1_ss_low",     ss0,    1'b0);
    chk("t1_mosi_b7",    mosi0,  1'b0);
    wait_ready(0, n);
    chk("t1_req_to_ready", 32'(n + 1), 32'd77);
    chk("t1_frame",  last_frame[0], 8'h45);
    chk("t1_sslen",  32'(last_sslen[0]), 32'd72);
    chk("t1_falls",  32'(last_falls[0]), 32'd8);
    chk("t1_done",   32'(done_cnt[0] - d0), 32'd1);
    chk("t1_nframe", 32'(nframe[0] - nf0), 32'd1);
    chk("t1_ph_min", 32'(ph_min[0]), 32'd4);
    chk("t1_ph_max", 32'(ph_max[0]), 32'd4);

    // Back-to-back with start held high.
    d0 = done_cnt[0]; nf0 = nframe[0];
    op0 = 3'b110; data0 = 4'b1111; start0 = 1'b1;
    tick();
    op0 = 3'b000; data0 = 4'b0000;
    wait_ready(0, n);
    chk("t2_first_len", 32'(n), 32'd76);
    tick();
    chk("t2_accept_immediate", ready0, 1'b0);
    start0 = 1'b0;
    wait_ready(0, n);
    chk("t2_frame_a", prev_frame[0], 8'h6F);
    chk("t2_frame_b", last_frame[0], 8'h00);
    chk("t2_gap_ge5", 32'(last_gap[0] >= 5), 32'd1);
    chk("t2_done",    32'(done_cnt[0] - d0), 32'd2);
    chk("t2_nframe",  32'(nframe[0] - nf0), 32'd2);

    // start during a frame is ignored; op/data changes do not leak in.
    d0 = done_cnt[0]; nf0 = nframe[0];
    op0 = 3'b010; data0 = 4'b1001; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (19) tick();
    op0 = 3'b111; data0 = 4'b1111; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("t3_busy", ready0, 1'b0);
    wait_ready(0, n);
    chk("t3_remaining", 32'(n), 32'd56);
    chk("t3_frame",  last_frame[0], 8'h29);
    repeat (8) tick();
    chk("t3_nframe", 32'(nframe[0] - nf0), 32'd1);
    chk("t3_ss_idle", ss0, 1'b1);
    chk("t3_not_queued", ready0, 1'b1);

    // Reset mid-frame, then a fresh sub frame.
    d0 = done_cnt[0]; nf0 = nframe[0];
    op0 = 3'b100; data0 = 4'b0001; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (29) tick();
    chk("t4_pre_rst_sclk", sclk0, 1'b1);
    rst0 = 1'b1;
    #1;
    chk("t4_rst_ss",    ss0,    1'b1);
    chk("t4_rst_sclk",  sclk0,  1'b0);
    chk("t4_rst_mosi",  mosi0,  1'b1);
    chk("t4_rst_ready", ready0, 1'b1);
    tick(); tick();
    rst0 = 1'b0;
    tick();
    chk("t4_no_done",   32'(done_cnt[0] - d0), 32'd0);
    chk("t4_no_frame",  32'(nframe[0] - nf0), 32'd0);
    op0 = 3'b001; data0 = 4'b0011; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_ready(0, n);
    chk("t4_len",   32'(n), 32'd76);
    chk("t4_frame", last_frame[0], 8'h13);
    chk("t4_sslen", 32'(last_sslen[0]), 32'd72);
    chk("t4_falls", 32'(last_falls[0]), 32'd8);
    chk("t4_done",  32'(done_cnt[0] - d0), 32'd1);
    chk("t4_alu_sub", alu_r, 4'd6);

    // Loopback: load A=3, load B=2, add.
    send0(3'b100, 4'b0011);
    send0(3'b110, 4'b0010);
    send0(3'b000, 4'b0000);
    chk("t5_alu_a", alu_a, 4'd3);
    chk("t5_alu_b", alu_b, 4'd2);
    chk("t5_alu_r", alu_r, 4'd5);
    chk("t5_viol",  32'(viol[0]), 32'd0);

    // DIV=2 instance.
    d1 = done_cnt[1];
    op1 = 3'b111; data1 = 4'b1010; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t6_ss_low", ss1, 1'b0);
    wait_ready(1, n);
    chk("t6_len",    32'(n), 32'd38);
    chk("t6_frame",  last_frame[1], 8'h7A);
    chk("t6_sslen",  32'(last_sslen[1]), 32'd36);
    chk("t6_falls",  32'(last_falls[1]), 32'd8);
    chk("t6_ph_min", 32'(ph_min[1]), 32'd2);
    chk("t6_ph_max", 32'(ph_max[1]), 32'd2);
    chk("t6_done",   32'(done_cnt[1] - d1), 32'd1);
    chk("t6_viol",   32'(viol[1]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
